uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one uart_tx instance between NUM_REQ byte requesters. It latches the granted requester's byte and parity mode and issues a one-cycle SEND. It then tracks BUSY through the whole frame and reports acceptance, completion and start-timeout per requester. The block sits between the application-side byte producers and the uart_tx SEND/DIN/PARITY_MODE/BUSY interface.

---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Latches the winner's byte and parity, pulses SEND, then follows BUSY to report DONE or ERR.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_PARITY,
  output logic [NUM_REQ-1:0]   ACK,
  output logic [NUM_REQ-1:0]   DONE,
  output logic [NUM_REQ-1:0]   ERR,
  output logic [2:0]           GRANT_ID,
  output logic                 ARB_BUSY,
  output logic                 TX_SEND,
  output logic [7:0]           TX_DIN,
  output logic                 TX_PARITY_MODE,
  input  logic                 TX_BUSY,
  output logic [1:0]           DBG_STATE
);

  // Handshake: REQ[i] acts as valid and is held with its byte until ACK[i] pulses;
  // ACK[i] is the one-cycle ready/accept, after which the slice may change freely.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  localparam int CW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

  state_t             state;
  logic [2:0]         ptr;
  logic [CW-1:0]      cnt;
  logic               win_found;
  logic [2:0]         win_id;
  logic [7:0]         win_data;
  logic               win_par;
  logic [NUM_REQ-1:0] grant_oh;

  assign DBG_STATE = state;
  assign grant_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << GRANT_ID;

  // First requesting index scanning upward from ptr+1 with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    win_data  = 8'h00;
    win_par   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && REQ[i] && (i == ((int'(ptr) + k) % NUM_REQ))) begin
          win_found = 1'b1;
          win_id    = 3'(i);
          win_data  = REQ_DATA[8*i +: 8];
          win_par   = REQ_PARITY[i];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state          <= IDLE;
      ptr            <= 3'(NUM_REQ-1);
      cnt            <= '0;
      ACK            <= '0;
      DONE           <= '0;
      ERR            <= '0;
      TX_SEND        <= 1'b0;
      TX_DIN         <= 8'h00;
      TX_PARITY_MODE <= 1'b0;
      GRANT_ID       <= 3'd0;
      ARB_BUSY       <= 1'b0;
    end else begin
      ACK     <= '0;
      DONE    <= '0;
      ERR     <= '0;
      TX_SEND <= 1'b0;
      case (state)
        IDLE: begin
          // A frame may still be draining after reset; never SEND over it.
          if (!TX_BUSY && win_found) begin
            TX_DIN         <= win_data;
            TX_PARITY_MODE <= win_par;
            GRANT_ID       <= win_id;
            TX_SEND        <= 1'b1;
            ACK            <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
            ARB_BUSY       <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (TX_BUSY) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(START_TIMEOUT-2)) begin
            // The count would reach START_TIMEOUT-1 on this edge: give up.
            ERR      <= grant_oh;
            ptr      <= GRANT_ID;
            ARB_BUSY <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY) begin
            DONE     <= grant_oh;
            ptr      <= GRANT_ID;
            ARB_BUSY <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of single frames plus hand sequences
// for timeout, BUSY-through-reset, reset mid-frame and REQ toggling.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]  req_par = '0;
  logic [N-1:0]  ack, done, err;
  logic [2:0]    grant_id;
  logic          arb_busy, tx_send, tx_par;
  logic [7:0]    tx_din;
  logic          tx_busy = 1'b0;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic       do_rst;
    logic [3:0] req;
    logic [31:0] data;
    logic [3:0] par;
    logic [3:0] req_after;
    logic [2:0] exp_id;
    logic [7:0] exp_din;
    logic       exp_par;
    int         len;
  } vec_t;
  vec_t vecs[6];

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst_n), .REQ(req), .REQ_DATA(req_data), .REQ_PARITY(req_par),
    .ACK(ack), .DONE(done), .ERR(err), .GRANT_ID(grant_id), .ARB_BUSY(arb_busy),
    .TX_SEND(tx_send), .TX_DIN(tx_din), .TX_PARITY_MODE(tx_par), .TX_BUSY(tx_busy),
    .DBG_STATE(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic expect_grant(input logic [2:0] id, input logic [7:0] din, input logic par);
    exp_q.push_back({par, id, din});
  endtask

  // Waits for SEND, scores it against the queue head, then applies the post-ACK REQ.
  task automatic wait_send(input logic [3:0] req_after);
    logic [11:0] e;
    int w;
    w = 0;
    while (!tx_send && w < 40) begin
      tick();
      w++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'h000;
    check("send_seen", 32'(tx_send), 32'd1);
    check("send_latency", 32'(w), 32'd1);
    check("tx_din", 32'(tx_din), 32'(e[7:0]));
    check("tx_parity", 32'(tx_par), 32'(e[11]));
    check("grant_id", 32'(grant_id), 32'(e[10:8]));
    check("ack", 32'(ack), 32'(4'b0001 << e[10:8]));
    req = req_after;
  endtask

  // BUSY rises 2 cycles after SEND and is held len cycles; DONE is due on the next edge.
  task automatic finish_frame(input logic [2:0] id, input logic [7:0] din, input int len,
                              input int toggle);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < len + 2; i++) begin
      tick();
      if (i == 1) tx_busy = 1'b1;
      if (done !== '0 || err !== '0 || ack !== '0 || tx_send !== 1'b0 ||
          tx_din !== din || arb_busy !== 1'b1) bad = 1'b1;
      if (toggle >= 0 && i == len/2) req[toggle] = 1'b0;
      if (toggle >= 0 && i == len/2 + 3) req[toggle] = 1'b1;
    end
    check("frame_quiet", 32'(bad), 32'd0);
    tx_busy = 1'b0;
    tick();
    check("done", 32'(done), 32'(4'b0001 << id));
    check("err_on_done", 32'(err), 32'd0);
    check("idle_after_done", {30'd0, arb_busy, dbg_state != 2'd0}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack_done_err"}, {20'd0, ack, done, err}, 32'd0);
    check({tag, "_send"}, 32'(tx_send), 32'd0);
    check({tag, "_din_par"}, {23'd0, tx_par, tx_din}, 32'd0);
    check({tag, "_grant"}, 32'(grant_id), 32'd0);
    check({tag, "_busy_state"}, {29'd0, arb_busy, dbg_state}, 32'd0);
  endtask

  initial begin
    logic bad;

    vecs[0] = '{1'b0, 4'b0010, 32'h0000_A500, 4'b0010, 4'b0000, 3'd1, 8'hA5, 1'b1, 100};
    vecs[1] = '{1'b1, 4'b1111, 32'h4433_2211, 4'b1010, 4'b1111, 3'd0, 8'h11, 1'b0, 20};
    vecs[2] = '{1'b0, 4'b1111, 32'h4433_2211, 4'b1010, 4'b1111, 3'd1, 8'h22, 1'b1, 20};
    vecs[3] = '{1'b0, 4'b1111, 32'h4433_2211, 4'b1010, 4'b1111, 3'd2, 8'h33, 1'b0, 20};
    vecs[4] = '{1'b0, 4'b1111, 32'h4433_2211, 4'b1010, 4'b1111, 3'd3, 8'h44, 1'b1, 20};
    vecs[5] = '{1'b0, 4'b1111, 32'h4433_2211, 4'b1010, 4'b0000, 3'd0, 8'h11, 1'b0, 20};

    apply_reset();
    check_reset_values("reset");

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_rst) apply_reset();
      req      = vecs[v].req;
      req_data = vecs[v].data;
      req_par  = vecs[v].par;
      expect_grant(vecs[v].exp_id, vecs[v].exp_din, vecs[v].exp_par);
      wait_send(vecs[v].req_after);
      finish_frame(vecs[v].exp_id, vecs[v].exp_din, vecs[v].len, -1);
    end

    // Start timeout on requester 2; requester 3 must be next.
    req_data = 32'hE75C_0000;
    req_par  = 4'b1000;
    req      = 4'b0100;
    expect_grant(3'd2, 8'h5C, 1'b0);
    wait_send(4'b1000);
    bad = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      tick();
      if (c < TO && (err !== '0 || done !== '0)) bad = 1'b1;
    end
    check("timeout_early", 32'(bad), 32'd0);
    check("timeout_err", 32'(err), 32'b0100);
    check("timeout_no_done", 32'(done), 32'd0);
    check("timeout_idle", {30'd0, arb_busy, dbg_state != 2'd0}, 32'd0);
    expect_grant(3'd3, 8'hE7, 1'b1);
    wait_send(4'b0000);
    finish_frame(3'd3, 8'hE7, 10, -1);

    // BUSY held across reset release: nothing may be sent until it drops.
    tx_busy = 1'b1;
    rst_n   = 1'b0;
    tick();
    tick();
    req_data = 32'h0000_003C;
    req_par  = 4'b0001;
    req      = 4'b0001;
    rst_n    = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (tx_send !== 1'b0 || arb_busy !== 1'b0) bad = 1'b1;
    end
    check("busy_hold_no_send", 32'(bad), 32'd0);
    tx_busy = 1'b0;
    expect_grant(3'd0, 8'h3C, 1'b1);
    wait_send(4'b0000);
    finish_frame(3'd0, 8'h3C, 10, -1);

    // Reset during WAIT_DONE abandons the frame silently.
    req_data = 32'h0096_0000;
    req_par  = 4'b0000;
    req      = 4'b0100;
    expect_grant(3'd2, 8'h96, 1'b0);
    wait_send(4'b0000);
    tick();
    tick();
    tx_busy = 1'b1;
    repeat (6) tick();
    check("in_wait_done", 32'(dbg_state), 32'd3);
    rst_n = 1'b0;
    tick();
    check_reset_values("midframe_reset");
    tx_busy = 1'b0;
    tick();
    check("reset_no_pulse", {28'd0, done, err} , 32'd0);
    rst_n = 1'b1;

    // Requester 0 has priority again; REQ[1] toggling mid-frame has no effect.
    req_data = 32'h0000_C35A;
    req_par  = 4'b0010;
    req      = 4'b0011;
    expect_grant(3'd0, 8'h5A, 1'b0);
    wait_send(4'b0010);
    finish_frame(3'd0, 8'h5A, 12, 1);
    expect_grant(3'd1, 8'hC3, 1'b1);
    wait_send(4'b0000);
    finish_frame(3'd1, 8'hC3, 8, -1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
